// File: rtl/fsm_mon_pkg.sv
// Shared types and helpers for the FSM transition monitor.
// Width constants here are the default state/count widths of the monitor.
package fsm_mon_pkg;

  localparam int unsigned MON_STATE_W = 6;
  localparam int unsigned MON_CNT_W   = 8;

  typedef struct packed {
    logic [MON_STATE_W-1:0] from_st;
    logic [MON_STATE_W-1:0] to_st;
    logic [MON_CNT_W-1:0]   thresh;
  } chan_cfg_t;

  // Saturating increment on a 32-bit carrier; callers narrow the result.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fsm_tm_channel.sv
// One watched transition: holds its configuration, saturating hit count and alarm.
// alarm_d_o exposes the next alarm so the top can register alarm_any alongside it.
module fsm_tm_channel
  import fsm_mon_pkg::*;
#(
  parameter int unsigned STATE_W = MON_STATE_W,
  parameter int unsigned CNT_W   = MON_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic               sticky_i,
  input  logic               cfg_we_i,
  input  logic [STATE_W-1:0] cfg_from_i,
  input  logic [STATE_W-1:0] cfg_to_i,
  input  logic [CNT_W-1:0]   cfg_thresh_i,
  input  logic               sample_i,
  input  logic [STATE_W-1:0] prev_state_i,
  input  logic [STATE_W-1:0] cur_state_i,
  input  logic               win_wrap_i,
  output logic               alarm_o,
  output logic               alarm_d_o,
  output logic [CNT_W-1:0]   count_o
);

  typedef struct packed {
    logic [STATE_W-1:0] from_st;
    logic [STATE_W-1:0] to_st;
    logic [CNT_W-1:0]   thresh;
  } cfg_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  cfg_t             cfg_q, cfg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, base;
  logic             alarm_q, alarm_d;
  logic             hit, reach;

  always_comb begin
    cfg_d   = cfg_q;
    cnt_d   = cnt_q;
    alarm_d = alarm_q;
    reach   = 1'b0;
    if (cfg_we_i) begin
      cfg_d.from_st = cfg_from_i;
      cfg_d.to_st   = cfg_to_i;
      cfg_d.thresh  = cfg_thresh_i;
    end
    hit  = sample_i && (prev_state_i == cfg_q.from_st) && (cur_state_i == cfg_q.to_st)
           && (cfg_q.thresh != '0);
    // A hit on the wrap edge is counted into the freshly cleared window.
    base = win_wrap_i ? '0 : cnt_q;
    if (clr_i || cfg_we_i) begin
      cnt_d   = '0;
      alarm_d = 1'b0;
    end else if (en_i) begin
      cnt_d   = hit ? CNT_W'(sat_inc(32'(base), 32'(CNT_MAX))) : base;
      reach   = (cfg_q.thresh != '0) && (cnt_d >= cfg_q.thresh);
      alarm_d = sticky_i ? (alarm_q | reach) : reach;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q   <= '0;
      cnt_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      alarm_q <= alarm_d;
    end
  end

  assign alarm_o   = alarm_q;
  assign alarm_d_o = alarm_d;
  assign count_o   = cnt_q;

endmodule

// File: rtl/fsm_transition_monitor.sv
// Observational monitor counting programmed state-to-state transitions of a host FSM.
// Holds the previous-state sample, the observation window counter and channel decode.
module fsm_transition_monitor
  import fsm_mon_pkg::*;
#(
  parameter int unsigned STATE_W = MON_STATE_W,
  parameter int unsigned N_CH    = 4,
  parameter int unsigned CNT_W   = MON_CNT_W,
  parameter int unsigned WIN_W   = 16,
  localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  state_valid,
  input  logic [STATE_W-1:0]    pr_state,
  input  logic                  cfg_we,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [STATE_W-1:0]    cfg_from,
  input  logic [STATE_W-1:0]    cfg_to,
  input  logic [CNT_W-1:0]      cfg_thresh,
  input  logic [WIN_W-1:0]      win_len,
  input  logic                  sticky,
  output logic [N_CH-1:0]       alarm,
  output logic                  alarm_any,
  output logic [N_CH*CNT_W-1:0] counts
);

  logic [STATE_W-1:0] prev_state_q, prev_state_d;
  logic               prev_valid_q, prev_valid_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic               win_wrap, sample;
  logic [N_CH-1:0]    alarm_nxt;
  logic               alarm_any_q;

  always_comb begin
    sample       = en && state_valid && prev_valid_q;
    // >= rather than == so a shrunk win_len wraps on the next enabled edge.
    win_wrap     = en && !clr && (win_len != '0) && (win_cnt_q >= win_len - 1'b1);
    prev_state_d = en ? pr_state : prev_state_q;
    // A disabled cycle breaks the chain so re-enable only primes prev_state.
    prev_valid_d = en && state_valid && !clr;
    win_cnt_d    = win_cnt_q;
    if (clr) begin
      win_cnt_d = '0;
    end else if (en && (win_len != '0)) begin
      win_cnt_d = win_wrap ? '0 : win_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_state_q <= '0;
      prev_valid_q <= 1'b0;
      win_cnt_q    <= '0;
      alarm_any_q  <= 1'b0;
    end else begin
      prev_state_q <= prev_state_d;
      prev_valid_q <= prev_valid_d;
      win_cnt_q    <= win_cnt_d;
      alarm_any_q  <= |alarm_nxt;
    end
  end

  assign alarm_any = alarm_any_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic sel;
    always_comb sel = cfg_we && (32'(cfg_ch) == i);

    fsm_tm_channel #(
      .STATE_W(STATE_W),
      .CNT_W  (CNT_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .en_i        (en),
      .clr_i       (clr),
      .sticky_i    (sticky),
      .cfg_we_i    (sel),
      .cfg_from_i  (cfg_from),
      .cfg_to_i    (cfg_to),
      .cfg_thresh_i(cfg_thresh),
      .sample_i    (sample),
      .prev_state_i(prev_state_q),
      .cur_state_i (pr_state),
      .win_wrap_i  (win_wrap),
      .alarm_o     (alarm[i]),
      .alarm_d_o   (alarm_nxt[i]),
      .count_o     (counts[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_fsm_transition_monitor.sv
// Directed scoreboard bench for fsm_transition_monitor: expectations are queued as
// stimulus is driven and compared one time unit after the following rising edge.
module tb_fsm_transition_monitor;

  localparam int STATE_W = 6;
  localparam int N_CH    = 4;
  localparam int CNT_W   = 8;
  localparam int WIN_W   = 16;

  logic                  clk = 1'b0;
  logic                  rst, en, clr, state_valid, cfg_we, sticky;
  logic [STATE_W-1:0]    pr_state, cfg_from, cfg_to;
  logic [1:0]            cfg_ch;
  logic [CNT_W-1:0]      cfg_thresh;
  logic [WIN_W-1:0]      win_len;
  logic [N_CH-1:0]       alarm;
  logic                  alarm_any;
  logic [N_CH*CNT_W-1:0] counts;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    int          kind;   // 0 count, 1 alarm bit, 2 alarm_any
    int          ch;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  fsm_transition_monitor #(
    .STATE_W(STATE_W),
    .N_CH   (N_CH),
    .CNT_W  (CNT_W),
    .WIN_W  (WIN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .state_valid(state_valid),
    .pr_state   (pr_state),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_from   (cfg_from),
    .cfg_to     (cfg_to),
    .cfg_thresh (cfg_thresh),
    .win_len    (win_len),
    .sticky     (sticky),
    .alarm      (alarm),
    .alarm_any  (alarm_any),
    .counts     (counts)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] observe(input int kind, input int ch);
    case (kind)
      0:       return 32'(counts[ch*CNT_W +: CNT_W]);
      1:       return 32'(alarm[ch]);
      default: return 32'(alarm_any);
    endcase
  endfunction

  task automatic push(input string tag, input int kind, input int ch, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.kind = kind; e.ch = ch; e.val = v;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.kind, e.ch);
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_sb();
  endtask

  // Drive one state sample and expect the given channel's count/alarm after the edge.
  task automatic step(input string tag, input logic [STATE_W-1:0] st, input logic v,
                      input int ch, input int cnt, input logic al);
    @(negedge clk);
    pr_state    = st;
    state_valid = v;
    push({tag, "_cnt"}, 0, ch, 32'(cnt));
    push({tag, "_alarm"}, 1, ch, 32'(al));
    tick();
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [STATE_W-1:0] f,
                     input logic [STATE_W-1:0] t, input logic [CNT_W-1:0] th);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = ch; cfg_from = f; cfg_to = t; cfg_thresh = th;
    push("cfg_cnt_cleared", 0, int'(ch), 0);
    push("cfg_alarm_cleared", 1, int'(ch), 0);
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; clr = 1'b0; state_valid = 1'b0; cfg_we = 1'b0; sticky = 1'b1;
    pr_state = '0; cfg_from = '0; cfg_to = '0; cfg_ch = '0; cfg_thresh = '0; win_len = '0;
    #12;
    for (int c = 0; c < N_CH; c++) begin
      push("reset_count", 0, c, 0);
      push("reset_alarm", 1, c, 0);
    end
    push("reset_alarm_any", 2, 0, 0);
    check_sb();
    @(negedge clk);
    rst = 1'b0;

    // Basic counting and sticky alarm timing on ch0: 13 -> 17, threshold 3
    cfg(2'd0, 6'd13, 6'd17, 8'd3);
    step("t1_13a", 6'd13, 1'b1, 0, 0, 1'b0);
    step("t1_17a", 6'd17, 1'b1, 0, 1, 1'b0);
    step("t1_13b", 6'd13, 1'b1, 0, 1, 1'b0);
    step("t1_17b", 6'd17, 1'b1, 0, 2, 1'b0);
    step("t1_13c", 6'd13, 1'b1, 0, 2, 1'b0);
    @(negedge clk);
    pr_state = 6'd17;
    push("t1_17c_cnt", 0, 0, 3);
    push("t1_17c_alarm", 1, 0, 1);
    push("t1_17c_any", 2, 0, 1);
    tick();
    @(negedge clk);
    pr_state = 6'd1;
    push("t1_hold_cnt", 0, 0, 3);
    push("t1_hold_alarm", 1, 0, 1);
    push("t1_hold_any", 2, 0, 1);
    tick();

    // Self-loop saturation on ch1: 21 -> 21, threshold 255
    cfg(2'd1, 6'd21, 6'd21, 8'd255);
    step("t2_prime", 6'd21, 1'b1, 1, 0, 1'b0);
    for (int i = 1; i < 300; i++) begin
      step("t2_loop", 6'd21, 1'b1, 1, (i > 255) ? 255 : i, (i >= 255));
    end

    // Windowed, non-sticky alarm on ch2: 5 -> 6, threshold 2, win_len 10
    cfg(2'd2, 6'd5, 6'd6, 8'd2);
    @(negedge clk);
    clr = 1'b1; win_len = 16'd10; sticky = 1'b0; pr_state = 6'd0;
    push("t3_clr_ch1", 0, 1, 0);
    push("t3_clr_ch2", 0, 2, 0);
    push("t3_clr_any", 2, 0, 0);
    tick();
    clr = 1'b0;
    step("t3_e1", 6'd5, 1'b1, 2, 0, 1'b0);
    step("t3_e2", 6'd6, 1'b1, 2, 1, 1'b0);
    step("t3_e3", 6'd5, 1'b1, 2, 1, 1'b0);
    step("t3_e4", 6'd6, 1'b1, 2, 2, 1'b1);
    for (int i = 5; i <= 8; i++) step("t3_idle", 6'd0, 1'b1, 2, 2, 1'b1);
    step("t3_e9", 6'd5, 1'b1, 2, 2, 1'b1);
    @(negedge clk);
    pr_state = 6'd6;
    push("t3_wrap_cnt", 0, 2, 1);
    push("t3_wrap_alarm", 1, 2, 0);
    push("t3_wrap_any", 2, 0, 0);
    tick();
    step("t3_e11", 6'd0, 1'b1, 2, 1, 1'b0);

    // Config write coinciding with a ch0 hit
    @(negedge clk);
    win_len = '0; sticky = 1'b1;
    step("t4_13a", 6'd13, 1'b1, 0, 0, 1'b0);
    step("t4_17a", 6'd17, 1'b1, 0, 1, 1'b0);
    step("t4_13b", 6'd13, 1'b1, 0, 1, 1'b0);
    step("t4_17b", 6'd17, 1'b1, 0, 2, 1'b0);
    step("t4_13c", 6'd13, 1'b1, 0, 2, 1'b0);
    @(negedge clk);
    pr_state = 6'd17; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_from = 6'd30; cfg_to = 6'd31; cfg_thresh = 8'd1;
    push("t4_we_cnt", 0, 0, 0);
    push("t4_we_alarm", 1, 0, 0);
    tick();
    cfg_we = 1'b0;
    step("t4_30", 6'd30, 1'b1, 0, 0, 1'b0);
    step("t4_31", 6'd31, 1'b1, 0, 1, 1'b1);
    step("t4_old13", 6'd13, 1'b1, 0, 1, 1'b1);
    step("t4_old17", 6'd17, 1'b1, 0, 1, 1'b1);

    // Chain breaks: state_valid low, en low, clr pulse
    cfg(2'd0, 6'd13, 6'd17, 8'd3);
    @(negedge clk);
    push("t5_any_low", 2, 0, 0);
    tick();
    step("t5_v13", 6'd13, 1'b1, 0, 0, 1'b0);
    step("t5_vinv", 6'd0, 1'b0, 0, 0, 1'b0);
    step("t5_v17", 6'd17, 1'b1, 0, 0, 1'b0);
    step("t5_e13", 6'd13, 1'b1, 0, 0, 1'b0);
    @(negedge clk);
    en = 1'b0; pr_state = 6'd5;
    push("t5_en_off", 0, 0, 0);
    tick();
    @(negedge clk);
    en = 1'b1;
    step("t5_e17", 6'd17, 1'b1, 0, 0, 1'b0);
    step("t5_c13", 6'd13, 1'b1, 0, 0, 1'b0);
    @(negedge clk);
    clr = 1'b1;
    push("t5_clr", 0, 0, 0);
    tick();
    clr = 1'b0;
    step("t5_c17", 6'd17, 1'b1, 0, 0, 1'b0);
    step("t5_cfg13", 6'd13, 1'b1, 0, 0, 1'b0);
    step("t5_cfg17", 6'd17, 1'b1, 0, 1, 1'b0);

    // Asynchronous reset while an alarm is high
    step("t6_13a", 6'd13, 1'b1, 0, 1, 1'b0);
    step("t6_17a", 6'd17, 1'b1, 0, 2, 1'b0);
    step("t6_13b", 6'd13, 1'b1, 0, 2, 1'b0);
    step("t6_17b", 6'd17, 1'b1, 0, 3, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    push("t6_rst_cnt", 0, 0, 0);
    push("t6_rst_alarm", 1, 0, 0);
    push("t6_rst_any", 2, 0, 0);
    push("t6_rst_ch2", 0, 2, 0);
    check_sb();
    @(negedge clk);
    rst = 1'b0;
    step("t6_post13a", 6'd13, 1'b1, 0, 0, 1'b0);
    step("t6_post17a", 6'd17, 1'b1, 0, 0, 1'b0);
    step("t6_post13b", 6'd13, 1'b1, 0, 0, 1'b0);
    step("t6_post17b", 6'd17, 1'b1, 0, 0, 1'b0);
    @(negedge clk);
    push("t6_post_any", 2, 0, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fsm_transition_monitor.md
Name: fsm_transition_monitor

Overview:
- Parametrised run-time monitor for the benchmark FSMs. It watches the present-state bus of a host FSM and counts occurrences of up to N_CH programmable state-to-state transitions.
- A per-channel alarm is raised when a count reaches its programmed threshold. This flags rare or looping transitions, such as a hidden counter-gated exit from a state.
- It sits beside the host FSM and is purely observational; it never drives host state.

Parameters:
- STATE_W, 6, width of the observed state encoding.
- N_CH, 4, number of independent watched transitions.
- CNT_W, 8, per-channel hit-counter width; counters saturate.
- WIN_W, 16, width of the observation-window length.

Ports:
- clk  in  1  sampling clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  global enable; when low, no sampling, counting or window advance.
- clr  in  1  synchronous clear of all counts, alarms, window counter and previous-state valid.
- state_valid  in  1  pr_state is meaningful this cycle.
- pr_state  in  STATE_W  host FSM present state.
- cfg_we  in  1  write configuration of channel cfg_ch.
- cfg_ch  in  $clog2(N_CH)  channel index; indices >= N_CH are ignored.
- cfg_from  in  STATE_W  watched source state.
- cfg_to  in  STATE_W  watched destination state.
- cfg_thresh  in  CNT_W  alarm threshold; 0 disables the channel.
- win_len  in  WIN_W  window length in enabled cycles; 0 means an infinite window.
- sticky  in  1  1 = alarms latch until clr or cfg write; 0 = alarm follows count>=thresh.
- alarm  out  N_CH  per-channel alarm.
- alarm_any  out  1  OR of alarm, registered with alarm (no extra latency).
- counts  out  N_CH*CNT_W  per-channel hit counts; channel i occupies bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset: all cfg fields 0 (all channels disabled), counts 0, alarm 0, alarm_any 0, prev_state 0, prev_valid 0, window counter 0.
- Per enabled cycle (en=1), at the rising edge:
  - prev_state <= pr_state and prev_valid <= state_valid.
  - Hit on channel i: en && state_valid && prev_valid && prev_state==from_i && pr_state==to_i && thresh_i!=0.
  - Self-loop (from==to) hits every cycle the state is held.
- Count update: count_i <= count_i+1, saturating at 2^CNT_W-1; no wrap.
- Alarm latency: alarm_i is set on the same edge the count update makes count >= thresh_i. It is therefore visible the cycle after the second state of the completing transition is sampled.
- Window:
  - If win_len!=0, win_cnt increments each enabled cycle. At win_cnt==win_len-1 it wraps to 0 and all counts clear on that edge.
  - Hit on the wrap edge: count becomes 1 (the hit belongs to the new window). The alarm is re-evaluated against 1.
  - Changing win_len mid-run takes effect immediately; if win_cnt >= new win_len-1, the wrap fires on the next enabled edge.
- sticky=1: alarm bits only set; they are cleared by clr, by cfg_we to that channel, or by rst. Window wrap does not clear them.
- sticky=0: alarm_i <= (next count_i >= thresh_i), so it drops on window wrap.
- cfg_we:
  - Loads from/to/thresh for cfg_ch and clears that channel's count and alarm on the same edge.
  - A hit on that channel in the same cycle is discarded.
  - Other channels are unaffected. cfg_we acts regardless of en.
- clr has priority over hits, window wrap and cfg_we-clear. It does not alter the configuration. prev_valid <= 0, so no transition can be counted across a clr.
- en=0: all counter/window state holds; prev_state is not updated. On re-enable, the first sampled cycle only primes prev_state.
- rst mid-operation: immediate return to reset values, including configuration; outputs go to 0 asynchronously.
- state_valid=0 breaks the chain: the next valid sample only primes prev_state.

Decomposition:
- Package fsm_mon_pkg holds:
  - a channel config struct: from, to, thresh;
  - a helper function for saturating increment.
- The package's parameter defaults must match STATE_W/CNT_W.
- Sub-module fsm_tm_channel, one instance per channel via generate. It holds config, count and alarm, and takes hit-qualifier inputs plus window_wrap, clr and sticky.
- The top level holds prev_state, the window counter, cfg decode and the alarm_any OR.

Test Plan:
- Transition counting and alarm timing:
  - Stimulus: rst, then cfg ch0 from=13, to=17, thresh=3, win_len=0, sticky=1. Drive state sequence 13,17,13,17,13,17.
  - Response: counts[0] is 1, 2, 3 after each 17. alarm[0] and alarm_any rise the cycle after the third 17 and stay high after the state moves to 1.
- Self-loop and saturation:
  - Stimulus: CNT_W=8, ch1 from=21, to=21, thresh=255. Hold 21 for 300 cycles.
  - Response: count reaches 255 and stays at 255 (no wrap). alarm[1] sets once the count reaches 255.
- Window wrap with non-sticky mode:
  - Stimulus: win_len=10, sticky=0, thresh=2. Place two hits inside window 1, then a hit exactly on the wrap edge.
  - Response: alarm high after the second hit. At the wrap, count=1 and alarm falls.
- Config write during a hit:
  - Stimulus: cfg_we to ch0 in the same cycle as a ch0 hit, with count at 2.
  - Response: count=0 and alarm=0 next cycle; the new from/to are used from the following sample.
- Break conditions:
  - Stimulus: a state_valid=0 cycle between 13 and 17, then en=0 between 13 and 17, then clr pulsed between 13 and 17.
  - Response: no count increment in any case, and clr leaves the configuration intact.
- Asynchronous reset:
  - Stimulus: rst asserted between clock edges while alarm=1.
  - Response: alarm and counts go to 0 immediately. After release, ch0 is disabled (thresh=0) and the 13→17 sequence produces no hits.
